// File: rtl/bist_pkg.sv
// Shared types and helpers for the comparator BIST engine.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } bist_state_e;

  localparam int DEFAULT_WIDTH = 2;
  localparam int NVEC          = 1 << (2 * DEFAULT_WIDTH);

  // Number of {x, y} operand pairs for a given operand width.
  function automatic int nvec(input int width);
    return 1 << (2 * width);
  endfunction

endpackage

// File: rtl/comparator_bist_if.sv
// Control/status and comparator-facing bus of the comparator BIST engine.
interface comparator_bist_if #(
  parameter int WIDTH = 2
);

  logic                 start;
  logic [WIDTH-1:0]     x_out;
  logic [WIDTH-1:0]     y_out;
  logic                 z_in;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [2*WIDTH:0]     err_count;
  logic [WIDTH-1:0]     fail_x;
  logic [WIDTH-1:0]     fail_y;

  modport master (
    input  start, z_in,
    output x_out, y_out, busy, done, pass, err_count, fail_x, fail_y
  );

  modport slave (
    output start, z_in,
    input  x_out, y_out, busy, done, pass, err_count, fail_x, fail_y
  );

endinterface

// File: rtl/bist_vec_counter.sv
// Operand-pair counter and settle-time counter for the comparator BIST engine.
module bist_vec_counter
  import bist_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vec_clr,
  input  logic               vec_inc,
  input  logic               settle_clr,
  input  logic               settle_en,
  output logic [2*WIDTH-1:0] vec,
  output logic               last_vec,
  output logic               settle_done
);

  localparam int VW          = 2 * WIDTH;
  localparam int SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SETTLE_LAST = (SETTLE > 0) ? (SETTLE - 1) : 0;

  logic [VW-1:0] vec_r;
  logic [SW-1:0] settle_r;

  // Vector index register: cleared at run start, stepped after each check.
  always_ff @(posedge clk) begin
    if (reset) begin
      vec_r <= '0;
    end else if (vec_clr) begin
      vec_r <= '0;
    end else if (vec_inc) begin
      vec_r <= vec_r + VW'(1);
    end else begin
      vec_r <= vec_r;
    end
  end

  // Settle counter: restarted on every drive, counts through the wait state.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle_r <= '0;
    end else if (settle_clr) begin
      settle_r <= '0;
    end else if (settle_en && !settle_done) begin
      settle_r <= settle_r + SW'(1);
    end else begin
      settle_r <= settle_r;
    end
  end

  assign vec         = vec_r;
  assign last_vec    = (vec_r == VW'(nvec(WIDTH) - 1));
  assign settle_done = (settle_r == SW'(SETTLE_LAST));

endmodule

// File: rtl/comparator_bist.sv
// Stimulus/response BIST for an equality comparator: walks every {x, y} pair,
// samples z after a settle window and records mismatches.
module comparator_bist
  import bist_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  comparator_bist_if.master bus
);

  localparam int VW = 2 * WIDTH;
  localparam int EW = 2 * WIDTH + 1;

  bist_state_e      state_r;
  bist_state_e      next_state_s;

  logic [VW-1:0]    vec_s;
  logic             last_vec_s;
  logic             settle_done_s;
  logic             clr_run_s;
  logic             vec_inc_s;
  logic             settle_clr_s;
  logic             settle_en_s;
  logic             expected_s;
  logic             mismatch_s;
  logic             busy_next_s;

  logic [WIDTH-1:0] x_out_r;
  logic [WIDTH-1:0] y_out_r;
  logic [EW-1:0]    err_count_r;
  logic [WIDTH-1:0] fail_x_r;
  logic [WIDTH-1:0] fail_y_r;
  logic             first_fail_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;

  bist_vec_counter #(
    .WIDTH  (WIDTH),
    .SETTLE (SETTLE)
  ) u_vec_counter (
    .clk         (clk),
    .reset       (reset),
    .vec_clr     (clr_run_s),
    .vec_inc     (vec_inc_s),
    .settle_clr  (settle_clr_s),
    .settle_en   (settle_en_s),
    .vec         (vec_s),
    .last_vec    (last_vec_s),
    .settle_done (settle_done_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          next_state_s = ST_DRIVE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (SETTLE > 0) begin
          next_state_s = ST_WAIT;
        end else begin
          next_state_s = ST_CHECK;
        end
      end
      ST_WAIT: begin
        if (settle_done_s) begin
          next_state_s = ST_CHECK;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_CHECK: begin
        if (last_vec_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_DRIVE;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          next_state_s = ST_DRIVE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Counter controls and the check decision for the current state.
  always_comb begin
    clr_run_s    = 1'b0;
    vec_inc_s    = 1'b0;
    settle_clr_s = 1'b0;
    settle_en_s  = 1'b0;
    busy_next_s  = 1'b0;
    expected_s   = (x_out_r == y_out_r);
    mismatch_s   = 1'b0;
    case (state_r)
      ST_IDLE:  clr_run_s    = 1'b1;
      ST_DRIVE: settle_clr_s = 1'b1;
      ST_WAIT:  settle_en_s  = 1'b1;
      ST_CHECK: begin
        vec_inc_s  = !last_vec_s;
        mismatch_s = (bus.z_in != expected_s);
      end
      ST_DONE:  clr_run_s    = bus.start;
      default:  clr_run_s    = 1'b0;
    endcase
    case (next_state_s)
      ST_DRIVE, ST_WAIT, ST_CHECK: busy_next_s = 1'b1;
      default:                     busy_next_s = 1'b0;
    endcase
  end

  // Operand drive, error accounting, first-fail capture and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_out_r      <= '0;
      y_out_r      <= '0;
      err_count_r  <= '0;
      fail_x_r     <= '0;
      fail_y_r     <= '0;
      first_fail_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
    end else begin
      if (state_r == ST_DRIVE) begin
        x_out_r <= vec_s[VW-1:WIDTH];
        y_out_r <= vec_s[WIDTH-1:0];
      end
      if (clr_run_s) begin
        err_count_r  <= '0;
        fail_x_r     <= '0;
        fail_y_r     <= '0;
        first_fail_r <= 1'b0;
      end else if (mismatch_s) begin
        err_count_r <= err_count_r + EW'(1);
        if (!first_fail_r) begin
          fail_x_r     <= x_out_r;
          fail_y_r     <= y_out_r;
          first_fail_r <= 1'b1;
        end
      end
      busy_r <= busy_next_s;
      done_r <= (state_r == ST_DONE);
      pass_r <= (state_r == ST_DONE) && (err_count_r == EW'(0));
    end
  end

  assign bus.x_out     = x_out_r;
  assign bus.y_out     = y_out_r;
  assign bus.err_count = err_count_r;
  assign bus.fail_x    = fail_x_r;
  assign bus.fail_y    = fail_y_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;

endmodule
